// File: rtl/mode_set.sv
// Mode selector: synchronizes and debounces the mode button, then steps a
// one-hot NORMAL -> TIMESET -> ALARMSET -> STOPWATCH cycle on each press.
module mode_set #(
    parameter int unsigned DEBOUNCE_CYCLES = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW_MODE,
    output logic TIMESET_RUN,
    output logic ALARMSET_RUN,
    output logic STOPWATCH_RUN
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [3:0] {
        NORMAL    = 4'b0001,
        TIMESET   = 4'b0010,
        ALARMSET  = 4'b0100,
        STOPWATCH = 4'b1000
    } mode_e;

    logic             s1;
    logic             s2;
    logic             db;
    logic             db_d;
    logic [CNT_W-1:0] cnt;
    logic             press;
    mode_e            state_q;
    mode_e            state_d;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= SW_MODE;
            s2 <= s1;
        end
    end

    // Level changes only after DEBOUNCE_CYCLES consecutive samples at the new level
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            db   <= 1'b0;
            cnt  <= '0;
            db_d <= 1'b0;
        end else begin
            db_d <= db;
            if (s2 != db) begin
                if (cnt == CNT_LAST) begin
                    db  <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = db & ~db_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (press) begin
            unique case (state_q)
                NORMAL:    state_d = TIMESET;
                TIMESET:   state_d = ALARMSET;
                ALARMSET:  state_d = STOPWATCH;
                STOPWATCH: state_d = NORMAL;
                default:   state_d = NORMAL;
            endcase
        end
    end

    // Run enables are the state flops themselves
    assign TIMESET_RUN   = state_q[1];
    assign ALARMSET_RUN  = state_q[2];
    assign STOPWATCH_RUN = state_q[3];

endmodule

// File: tb/tb_mode_set.sv
// Scoreboard bench for mode_set: stimulus queues expected output changes with
// their cycle, a negedge monitor pops and compares whenever outputs change.
module tb_mode_set;

    typedef struct {
        int         cyc;
        logic [2:0] outs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic sw_a, sw_b;
    logic ts_a, al_a, st_a;
    logic ts_b, al_b, st_b;
    logic [2:0] outs_a, outs_b;
    logic [2:0] prev_a, prev_b;
    logic mon_en;
    int cyc;
    int n_chk;
    int n_pass;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    mode_set #(.DEBOUNCE_CYCLES(1)) dut_a (
        .CLK(clk), .RST(rst_a), .SW_MODE(sw_a),
        .TIMESET_RUN(ts_a), .ALARMSET_RUN(al_a), .STOPWATCH_RUN(st_a)
    );

    mode_set #(.DEBOUNCE_CYCLES(4)) dut_b (
        .CLK(clk), .RST(rst_b), .SW_MODE(sw_b),
        .TIMESET_RUN(ts_b), .ALARMSET_RUN(al_b), .STOPWATCH_RUN(st_b)
    );

    assign outs_a = {st_a, al_a, ts_a};
    assign outs_b = {st_b, al_b, ts_b};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp_change(input string nm, input int act_cyc, input logic [2:0] act,
                              input int exp_cyc, input logic [2:0] exp_outs);
        n_chk++;
        if (act === exp_outs && act_cyc == exp_cyc) n_pass++;
        else $display("FAIL %s: got outs=%b at cycle %0d, expected outs=%b at cycle %0d",
                      nm, act, act_cyc, exp_outs, exp_cyc);
    endtask

    task automatic cmp_val(input string nm, input logic [2:0] act, input logic [2:0] exp_outs);
        n_chk++;
        if (act === exp_outs) n_pass++;
        else $display("FAIL %s: got %b, expected %b", nm, act, exp_outs);
    endtask

    // Monitor: one-hot check every cycle, scoreboard pop on every output change
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            n_chk += 2;
            if ($countones(outs_a) <= 1) n_pass++;
            else $display("FAIL onehot_a: got %b at cycle %0d, expected at most one bit", outs_a, cyc);
            if ($countones(outs_b) <= 1) n_pass++;
            else $display("FAIL onehot_b: got %b at cycle %0d, expected at most one bit", outs_b, cyc);
            if (outs_a !== prev_a) begin
                if (q_a.size() == 0) cmp_change("unexpected_a", cyc, outs_a, -1, prev_a);
                else begin
                    e = q_a.pop_front();
                    cmp_change("change_a", cyc, outs_a, e.cyc, e.outs);
                end
            end
            if (outs_b !== prev_b) begin
                if (q_b.size() == 0) cmp_change("unexpected_b", cyc, outs_b, -1, prev_b);
                else begin
                    e = q_b.pop_front();
                    cmp_change("change_b", cyc, outs_b, e.cyc, e.outs);
                end
            end
        end
        prev_a = outs_a;
        prev_b = outs_b;
    end

    // Press on dut_a: accepted press shows up 4 edges after the first sampling edge
    task automatic press_a(input logic [2:0] exp_outs, input int hi, input int lo);
        q_a.push_back('{cyc + 4, exp_outs});
        sw_a = 1'b1;
        repeat (hi) @(negedge clk);
        sw_a = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // High pulse on dut_b; when accept is set the press lands 7 edges later
    task automatic pulse_b(input bit accept, input logic [2:0] exp_outs, input int hi, input int lo);
        if (accept) q_b.push_back('{cyc + 7, exp_outs});
        sw_b = 1'b1;
        repeat (hi) @(negedge clk);
        sw_b = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        cyc = 0; n_chk = 0; n_pass = 0; mon_en = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0; sw_a = 1'b0; sw_b = 1'b0;
        prev_a = 3'b000; prev_b = 3'b000;
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        cmp_val("reset_a", outs_a, 3'b000);
        cmp_val("reset_b", outs_b, 3'b000);

        // DEBOUNCE_CYCLES=1: long hold gives a single event, then short pulses step the cycle
        press_a(3'b001, 6, 2);
        press_a(3'b010, 1, 2);
        press_a(3'b100, 1, 2);
        press_a(3'b000, 1, 2);
        press_a(3'b001, 1, 2);
        press_a(3'b010, 1, 2);
        q_a.push_back('{cyc + 4, 3'b100});
        sw_a = 1'b1;
        repeat (8) @(negedge clk);
        cmp_val("held_stopwatch_a", outs_a, 3'b100);

        // Asynchronous reset mid-cycle with the button held
        @(posedge clk);
        #2;
        rst_a = 1'b0;
        q_a.push_back('{cyc, 3'b000});
        #1;
        cmp_val("async_reset_a", outs_a, 3'b000);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        q_a.push_back('{cyc + 4, 3'b001});
        repeat (10) @(negedge clk);
        sw_a = 1'b0;
        repeat (4) @(negedge clk);

        // DEBOUNCE_CYCLES=4: short glitches rejected, full press accepted
        pulse_b(1'b0, 3'b000, 1, 8);
        pulse_b(1'b0, 3'b000, 2, 8);
        pulse_b(1'b0, 3'b000, 3, 8);
        cmp_val("glitch_b", outs_b, 3'b000);
        pulse_b(1'b1, 3'b001, 4, 8);
        pulse_b(1'b0, 3'b000, 1, 1);
        pulse_b(1'b0, 3'b000, 1, 1);
        pulse_b(1'b1, 3'b010, 6, 8);
        pulse_b(1'b0, 3'b000, 3, 8);
        cmp_val("midcount_b", outs_b, 3'b010);
        pulse_b(1'b1, 3'b100, 5, 8);

        repeat (10) @(negedge clk);
        n_chk += 2;
        if (q_a.size() == 0) n_pass++;
        else $display("FAIL pending_a: got %0d outstanding changes, expected 0", q_a.size());
        if (q_b.size() == 0) n_pass++;
        else $display("FAIL pending_b: got %0d outstanding changes, expected 0", q_b.size());
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
